// File: rtl/latch_stage_hs.sv
// latch_stage_hs: RV32 pipeline stage register (instr + PC) with valid/ready handshake,
// synchronous flush with NOP bubble and saturating stall counter. Optional macro: SKID_BUFFER_EN.
module latch_stage_hs #(
   parameter int                 INSTR_W   = 32,
   parameter int                 PC_W      = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013,
   parameter logic [PC_W-1:0]    RESET_PC  = 32'h00000000,
   parameter int                 CNT_W     = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic [CNT_W-1:0]   stall_count
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_FULL  = 2'd1;
   localparam logic [1:0] ST_SKID  = 2'd2;

   logic [1:0]         state;
   logic [1:0]         next_state;
   logic [INSTR_W-1:0] main_instr;
   logic [PC_W-1:0]    main_pc;
   logic               accept;
   logic               consume;
   logic               load_main;

   assign out_valid = (state != ST_EMPTY);
   assign accept    = in_valid && in_ready;
   assign consume   = out_valid && out_ready;
   // An empty stage presents a bubble; the PC is left as it was for debug visibility.
   assign out_instr = out_valid ? main_instr : NOP_INSTR;
   assign out_pc    = main_pc;

`ifdef SKID_BUFFER_EN
   logic [INSTR_W-1:0] skid_instr;
   logic [PC_W-1:0]    skid_pc;
   logic               ready_q;
   logic               load_skid;
   logic               main_from_skid;

   assign in_ready = ready_q;
`else
   assign in_ready = out_ready || !out_valid;
`endif

   always_comb begin
      next_state = state;
      load_main  = 1'b0;
`ifdef SKID_BUFFER_EN
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
`endif
      case (state)
         ST_EMPTY: begin
            if (accept) begin
               next_state = ST_FULL;
               load_main  = 1'b1;
            end
         end
         ST_FULL: begin
            if (accept && consume) begin
               load_main = 1'b1;
            end else if (consume) begin
               next_state = ST_EMPTY;
`ifdef SKID_BUFFER_EN
            end else if (accept) begin
               next_state = ST_SKID;
               load_skid  = 1'b1;
`endif
            end
         end
`ifdef SKID_BUFFER_EN
         ST_SKID: begin
            if (consume) begin
               next_state     = ST_FULL;
               load_main      = 1'b1;
               main_from_skid = 1'b1;
            end
         end
`endif
         default: next_state = ST_EMPTY;
      endcase
      // Flush discards everything held plus whatever is being accepted this cycle.
      if (flush) begin
         next_state = ST_EMPTY;
         load_main  = 1'b0;
`ifdef SKID_BUFFER_EN
         load_skid  = 1'b0;
`endif
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_EMPTY;
         main_instr <= NOP_INSTR;
         main_pc    <= RESET_PC;
      end else begin
         state <= next_state;
         if (load_main) begin
`ifdef SKID_BUFFER_EN
            main_instr <= main_from_skid ? skid_instr : in_instr;
            main_pc    <= main_from_skid ? skid_pc : in_pc;
`else
            main_instr <= in_instr;
            main_pc    <= in_pc;
`endif
         end
      end
   end

`ifdef SKID_BUFFER_EN
   // in_ready is precomputed from the next state so upstream never sees out_ready combinationally.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         skid_instr <= NOP_INSTR;
         skid_pc    <= RESET_PC;
         ready_q    <= 1'b1;
      end else begin
         ready_q <= (next_state != ST_SKID);
         if (load_skid) begin
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
         end
      end
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_count <= '0;
      end else if (in_valid && !in_ready && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_latch_stage_hs.sv
// tb_latch_stage_hs: directed stimulus with a scoreboard queue of expected stage outputs.
// Works for both builds; SKID_BUFFER_EN selects the expected capacity and ready behaviour.
module tb_latch_stage_hs;

`ifdef SKID_BUFFER_EN
   localparam int SKID_CAP = 2;
`else
   localparam int SKID_CAP = 1;
`endif
   localparam logic [31:0] NOP = 32'h00000013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_ready;

   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [15:0] stall_count;

   logic        s_in_ready;
   logic        s_out_valid;
   logic [31:0] s_out_instr;
   logic [31:0] s_out_pc;
   logic [1:0]  s_stall_count;

   entry_t      sb[$];
   logic [31:0] last_pc;
   int          stall_m;
   int          stall_s;
   logic [31:0] gen_instr;
   logic [31:0] gen_pc;
   logic        last_acc;
   int          checks = 0;
   int          errors = 0;

   latch_stage_hs dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .stall_count(stall_count)
   );

   latch_stage_hs #(.CNT_W(2)) dut_small (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr), .out_pc(s_out_pc),
      .stall_count(s_stall_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, check against the scoreboard mid-cycle, then advance the model.
   task automatic applyStimulus(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                                input logic ordy, input logic fl);
      logic        exp_ready;
      logic        con;
      logic [31:0] exp_instr;
      logic [31:0] exp_pc;
      in_valid  = iv;
      in_instr  = ins;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      #4;
      exp_ready = (sb.size() == 0) || ((SKID_CAP == 2) ? (sb.size() < 2) : ordy);
      exp_instr = NOP;
      exp_pc    = last_pc;
      if (sb.size() > 0) begin
         exp_instr = sb[0].instr;
         exp_pc    = sb[0].pc;
      end
      check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
      check("out_valid", {31'b0, out_valid}, {31'b0, sb.size() > 0});
      check("out_instr", out_instr, exp_instr);
      check("out_pc", out_pc, exp_pc);
      check("stall_count", {16'b0, stall_count}, stall_m);
      check("stall_count_small", {30'b0, s_stall_count}, stall_s);
      last_acc = iv && exp_ready;
      con      = (sb.size() > 0) && ordy;
      if (iv && !exp_ready) begin
         if (stall_m < 65535) stall_m++;
         if (stall_s < 3) stall_s++;
      end
      if (fl) begin
         if (sb.size() > 0) last_pc = sb[0].pc;
         sb.delete();
      end else begin
         if (con) begin
            last_pc = sb[0].pc;
            void'(sb.pop_front());
         end
         if (last_acc) sb.push_back({ins, pc});
      end
      @(posedge clock);
      #1;
   endtask

   // Upstream producer: holds its word until the handshake completes, then moves on.
   task automatic checkOutput(input logic iv, input logic ordy, input logic fl);
      applyStimulus(iv, gen_instr, gen_pc, ordy, fl);
      if (last_acc) begin
         gen_instr = gen_instr + 32'd1;
         gen_pc    = gen_pc + 32'd4;
      end
   endtask

   task automatic pulse_reset();
      in_valid = 1'b0;
      reset    = 1'b1;
      #1;
      check("reset_async_out_valid", {31'b0, out_valid}, 32'd0);
      check("reset_async_out_instr", out_instr, NOP);
      check("reset_async_out_pc", out_pc, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      sb.delete();
      last_pc = 32'd0;
      stall_m = 0;
      stall_s = 0;
      @(posedge clock);
      #1;
   endtask

   initial begin
      #20000;
      $display("[TB] FAIL timeout: observed no finish, expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = 32'd0;
      in_pc     = 32'd0;
      out_ready = 1'b0;
      last_pc   = 32'd0;
      stall_m   = 0;
      stall_s   = 0;
      last_acc  = 1'b0;
      #12;
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Test 1: idle after reset
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_instr", out_instr, 32'h13);
      check("rst_out_pc", out_pc, 32'h0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_stall_count", {16'b0, stall_count}, 32'd0);
      checkOutput(1'b0, 1'b1, 1'b0);

      // Test 2: streaming 0xA..0xD with downstream always ready
      gen_instr = 32'hA;
      gen_pc    = 32'h0;
      repeat (4) checkOutput(1'b1, 1'b1, 1'b0);
      repeat (2) checkOutput(1'b0, 1'b1, 1'b0);

      // Test 3: backpressure for three cycles, then release
      gen_instr = 32'h100;
      gen_pc    = 32'h40;
      repeat (3) checkOutput(1'b1, 1'b0, 1'b0);
      repeat (2) checkOutput(1'b1, 1'b1, 1'b0);
      repeat (3) checkOutput(1'b0, 1'b1, 1'b0);

      // Test 4: flush with the stage fully occupied
      repeat (2) checkOutput(1'b1, 1'b0, 1'b0);
      checkOutput(1'b1, 1'b0, 1'b1);
      check("flush_out_instr", out_instr, NOP);
      check("flush_in_ready", {31'b0, in_ready}, 32'd1);
      repeat (2) checkOutput(1'b1, 1'b1, 1'b0);
      repeat (2) checkOutput(1'b0, 1'b1, 1'b0);

      // Test 6: reset while full mid-stream
      repeat (2) checkOutput(1'b1, 1'b0, 1'b0);
      pulse_reset();
      repeat (2) checkOutput(1'b0, 1'b1, 1'b0);

      // Test 5: long backpressure saturates the 2-bit counter
      repeat (8) checkOutput(1'b1, 1'b0, 1'b0);
      check("sat_small", {30'b0, s_stall_count}, 32'd3);
      repeat (3) checkOutput(1'b1, 1'b1, 1'b0);
      repeat (3) checkOutput(1'b0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
